// File: rtl/cordic_vectoring_engine_if.sv
// Sample-in / result-out handshake bundle
// for the CORDIC vectoring engine.
interface cordic_vectoring_engine_if #(
  parameter int VALUE_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 8
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [VALUE_WIDTH:0]     x_in;
  logic [VALUE_WIDTH:0]     y_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [VALUE_WIDTH+1:0]   mag_out;
  logic [ADDRESS_WIDTH+1:0] angle_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );
endinterface

// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring CORDIC: (x,y) -> atan2
// phase and K-scaled magnitude, 1 step/clock.
module cordic_vectoring_engine #(
  parameter int VALUE_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ITERATIONS    = 8
) (
  input  logic CLK,
  input  logic RESET,
  cordic_vectoring_engine_if.slave bus
);
  localparam int XW = VALUE_WIDTH + 3;
  localparam int ZW = ADDRESS_WIDTH + 2;
  localparam int KW =
    (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [KW-1:0] K_LAST =
    KW'(ITERATIONS - 1);
  localparam logic [ZW-1:0] A90 =
    ZW'(1) << ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE, ITER, DONE
  } state_t;

  // atan(2^-k), 45 deg = 2^29, rescaled with
  // rounding to 45 deg = 2^(ADDRESS_WIDTH-1).
  function automatic logic [ZW-1:0] atan_lut(
    input logic [KW-1:0] k
  );
    logic [31:0] t;
    case (32'(k))
      0:  t = 32'd536870912;
      1:  t = 32'd316933406;
      2:  t = 32'd167458907;
      3:  t = 32'd85004756;
      4:  t = 32'd42667331;
      5:  t = 32'd21354465;
      6:  t = 32'd10679838;
      7:  t = 32'd5340245;
      8:  t = 32'd2670163;
      9:  t = 32'd1335087;
      10: t = 32'd667544;
      11: t = 32'd333772;
      12: t = 32'd166886;
      13: t = 32'd83443;
      14: t = 32'd41722;
      15: t = 32'd20861;
      default: t = 32'd0;
    endcase
    t = t + (32'd1 << (29 - ADDRESS_WIDTH));
    return ZW'(t >> (30 - ADDRESS_WIDTH));
  endfunction

  state_t state, state_nx;
  logic signed [XW-1:0] x, y;
  logic [ZW-1:0] z;
  logic [KW-1:0] k;
  logic zero;
  logic up;
  logic rdy;
  logic accept;

  logic signed [XW-1:0] xe, ye, xs, ys;

  assign rdy    = (state == IDLE) && up;
  assign accept = rdy && bus.in_valid;
  assign xe = {{2{bus.x_in[VALUE_WIDTH]}}, bus.x_in};
  assign ye = {{2{bus.y_in[VALUE_WIDTH]}}, bus.y_in};
  assign xs = x >>> k;
  assign ys = y >>> k;

  // State register; 'up' holds off in_ready
  // until the first edge after reset release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      up    <= 1'b0;
    end else begin
      state <= state_nx;
      up    <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = ITER;
      ITER: if (k == K_LAST) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture with quadrant pre-rotation, then
  // one micro-rotation per edge while in ITER.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      k    <= '0;
      zero <= 1'b0;
    end else if (accept) begin
      k    <= '0;
      zero <= (xe == '0) && (ye == '0);
      if (!xe[XW-1]) begin
        x <= xe;
        y <= ye;
        z <= '0;
      end else if (!ye[XW-1]) begin
        x <= ye;
        y <= -xe;
        z <= A90;
      end else begin
        x <= -ye;
        y <= xe;
        z <= -A90;
      end
    end else if (state == ITER) begin
      k <= k + KW'(1);
      if (!y[XW-1]) begin
        x <= x + ys;
        y <= y - xs;
        z <= z + atan_lut(k);
      end else begin
        x <= x - ys;
        y <= y + xs;
        z <= z - atan_lut(k);
      end
    end
  end

  // Handshake and result outputs.
  always_comb begin
    bus.in_ready  = rdy;
    bus.out_valid = (state == DONE);
    bus.mag_out   =
      zero ? '0 : x[VALUE_WIDTH+1:0];
    bus.angle_out = zero ? '0 : z;
  end
endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Randomized self-checking bench for the
// vectoring CORDIC against a real-valued model.
module tb_cordic_vectoring_engine;
  localparam int VW = 8;
  localparam int AW = 8;
  localparam int IT = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  cordic_vectoring_engine_if #(
    .VALUE_WIDTH(VW), .ADDRESS_WIDTH(AW)
  ) bus ();

  cordic_vectoring_engine #(
    .VALUE_WIDTH(VW),
    .ADDRESS_WIDTH(AW),
    .ITERATIONS(IT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_mag, exp_ang;
  bit have_exp = 1'b0;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  task automatic chk_near(string nm, int act,
                          int req, int tol);
    int d;
    checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d+/-%0d",
               nm, act, req, tol);
    end
  endtask

  function automatic int atan_ref(int k);
    real v;
    v = (2.0 ** (AW + 1)) / 3.14159265358979 *
        $atan(2.0 ** (-k));
    return int'($floor(v + 0.5));
  endfunction

  function automatic int wrap_ang(int a);
    int w;
    w = a & ((1 << (AW + 2)) - 1);
    if (w >= (1 << (AW + 1))) w -= (1 << (AW + 2));
    return w;
  endfunction

  // Reference: rotate the vector onto +x with
  // the specified step rules, in plain integers.
  task automatic model(input int xi, input int yi,
                       output int mag,
                       output int ang);
    int xv, yv, zv, xo, yo;
    if (xi == 0 && yi == 0) begin
      mag = 0;
      ang = 0;
      return;
    end
    if (xi >= 0) begin
      xv = xi; yv = yi; zv = 0;
    end else if (yi >= 0) begin
      xv = yi; yv = -xi; zv = 1 << AW;
    end else begin
      xv = -yi; yv = xi; zv = -(1 << AW);
    end
    for (int k = 0; k < IT; k++) begin
      xo = xv;
      yo = yv;
      if (yo >= 0) begin
        xv = xo + (yo >>> k);
        yv = yo - (xo >>> k);
        zv = zv + atan_ref(k);
      end else begin
        xv = xo - (yo >>> k);
        yv = yo + (xo >>> k);
        zv = zv - atan_ref(k);
      end
    end
    mag = xv & ((1 << (VW + 2)) - 1);
    ang = wrap_ang(zv);
  endtask

  // Every cycle a result is offered it must
  // match the model and the input side is shut.
  always @(negedge CLK) begin
    if (RESET && bus.out_valid) begin
      chk("expected_pending", int'(have_exp), 1);
      if (have_exp) begin
        chk("mag", int'(bus.mag_out), exp_mag);
        chk("angle",
            int'($signed(bus.angle_out)), exp_ang);
      end
      chk("in_ready_busy", int'(bus.in_ready), 0);
    end
  end

  task automatic run(int xv, int yv, int stall);
    int n, lat, m, a;
    logic [VW:0] xb, yb;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("in_ready_wait", int'(bus.in_ready), 1);
    if (!bus.in_ready) return;
    model(xv, yv, m, a);
    exp_mag = m;
    exp_ang = a;
    have_exp = 1'b1;
    xb = xv[VW:0];
    yb = yv[VW:0];
    bus.x_in = xb;
    bus.y_in = yb;
    bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    bus.x_in = VW'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", lat, IT);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x_in = (VW + 1)'($urandom);
      bus.y_in = (VW + 1)'($urandom);
      @(posedge CLK); #1;
      chk("stall_valid", int'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    have_exp = 1'b0;
    chk("handoff_valid", int'(bus.out_valid), 0);
    chk("handoff_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    int m, a, r;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    #2 RESET = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.mag_out), 0);
    chk("rst_angle", int'(bus.angle_out), 0);
    repeat (2) @(negedge CLK);
    chk("rst_hold_ready", int'(bus.in_ready), 0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("release_ready", int'(bus.in_ready), 1);

    model(100, 0, m, a);
    chk_near("ref_0deg_ang", a, 0, 2);
    chk_near("ref_0deg_mag", m, 165, 2);
    model(0, 100, m, a);
    chk_near("ref_90deg_ang", a, 256, 2);
    chk_near("ref_90deg_mag", m, 165, 2);
    model(100, 100, m, a);
    chk_near("ref_45deg_ang", a, 128, 2);
    chk_near("ref_45deg_mag", m, 233, 3);
    model(-100, 0, m, a);
    r = wrap_ang(a + 512);
    chk_near("ref_180deg_ang", r, 0, 2);
    model(-100, -100, m, a);
    chk_near("ref_m135deg_ang", a, -384, 2);
    model(0, 0, m, a);
    chk("ref_zero_mag", m, 0);
    chk("ref_zero_ang", a, 0);

    run(100, 0, 0);
    run(0, 100, 0);
    run(100, 100, 1);
    run(-100, 0, 0);
    run(-100, -100, 2);
    run(0, 0, 0);
    run(100, 0, 5);
    run(-256, -256, 0);
    run(-256, 255, 1);
    run(255, -256, 0);
    run(-256, 0, 0);
    run(0, -256, 0);

    model(50, -70, m, a);
    exp_mag = m;
    exp_ang = a;
    have_exp = 1'b1;
    bus.x_in = 9'sd50;
    bus.y_in = -9'sd70;
    bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    have_exp = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_ready", int'(bus.in_ready), 0);
    chk("midrst_mag", int'(bus.mag_out), 0);
    chk("midrst_angle", int'(bus.angle_out), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_release", int'(bus.in_ready), 1);
    run(-37, 91, 0);

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(0, 511) - 256,
          $urandom_range(0, 511) - 256,
          $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
